// File: rtl/bitwise_unit_arbiter_pkg.sv
// Shared constants and types for the two-requester bitwise unit.
package bitwise_unit_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic OP_AND = 1'b0;
    localparam logic OP_OR  = 1'b1;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/bitwise_unit_arbiter_bitwise.sv
// Plain combinational bitwise primitives shared by the unit.
module bitwise_and #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic [WIDTH-1:0] out
);

    assign out = in_0 & in_1;

endmodule

module bitwise_or #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    output logic [WIDTH-1:0] out
);

    assign out = in_0 | in_1;

endmodule

// File: rtl/bitwise_unit_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter; the previous winner loses the next contention.
module rr_arbiter_2
    import bitwise_unit_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    input  logic       fire,
    output logic [1:0] gnt
);

    logic last_grant;

    // Grant only when the output buffer can accept; a lone requester always wins.
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = accept && req[0] && (!req[1] || (last_grant == REQ1));
        gnt[1] = accept && req[1] && (!req[0] || (last_grant == REQ0));
    end

    // Remember the winner of the most recent transfer; starts so req0 wins first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= REQ1;
        end else if (fire) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/bitwise_unit_arbiter.sv
// Shares one AND/OR datapath between two requesters behind a one-entry result buffer.
module bitwise_unit_arbiter
    import bitwise_unit_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             resp_op
);

    buf_state_t       state;
    buf_state_t       state_next;
    logic             accept;
    logic [1:0]       gnt;
    logic             fire;
    logic             sel;
    logic             op_sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] and_out;
    logic [WIDTH-1:0] or_out;
    logic [WIDTH-1:0] result;

    // The buffer can take a new result when empty or when it drains this cycle.
    assign accept     = !resp_valid || resp_ready;
    assign fire       = |gnt;
    assign sel        = gnt[1];
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign resp_valid = (state == BUF_FULL);

    rr_arbiter_2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({req1_valid, req0_valid}),
        .accept  (accept),
        .fire    (fire),
        .gnt     (gnt)
    );

    // Steer the granted requester's operands onto the shared datapath.
    always_comb begin
        op_sel = req0_op;
        op_a   = req0_a;
        op_b   = req0_b;
        if (sel == REQ1) begin
            op_sel = req1_op;
            op_a   = req1_a;
            op_b   = req1_b;
        end
    end

    bitwise_and #(.WIDTH(WIDTH)) u_and (
        .in_0 (op_a),
        .in_1 (op_b),
        .out  (and_out)
    );

    bitwise_or #(.WIDTH(WIDTH)) u_or (
        .in_0 (op_a),
        .in_1 (op_b),
        .out  (or_out)
    );

    assign result = (op_sel == OP_OR) ? or_out : and_out;

    // Buffer occupancy register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Fill on transfer, drain on consumer ready, stay full on back-to-back.
    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (fire) state_next = BUF_FULL;
            BUF_FULL:  if (fire) state_next = BUF_FULL;
                       else if (resp_ready) state_next = BUF_EMPTY;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    // Payload captured only on a transfer, so it holds steady under backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_data <= '0;
            resp_id   <= REQ0;
            resp_op   <= OP_AND;
        end else if (fire) begin
            resp_data <= result;
            resp_id   <= sel;
            resp_op   <= op_sel;
        end
    end

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed-vector bench for bitwise_unit_arbiter.
module tb_bitwise_unit_arbiter;

    localparam int unsigned W = 32;

    logic         clock;
    logic         reset_n;
    logic         req0_valid;
    logic         req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic         req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_id;
    logic         resp_op;

    int tests_run    = 0;
    int tests_failed = 0;

    bitwise_unit_arbiter #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_op    (resp_op)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = '0; req1_b = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        resp_ready = 1'b1;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_id !== 1'b0 || resp_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%0d data=%0d id=%0d op=%0d, want 0 0 0 0",
                     resp_valid, resp_data, resp_id, resp_op);
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd1646; req0_b = 32'd5184;
        resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: r0=%0d r1=%0d, want 1 0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd1088 || resp_id !== 1'b0 || resp_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_resp: valid=%0d data=%0d id=%0d op=%0d, want 1 1088 0 0",
                     resp_valid, resp_data, resp_id, resp_op);
        end
        step();
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drain: valid=%0d, want 0", resp_valid);
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] exp_data [4];
        logic         exp_id   [4];
        exp_data[0] = 32'd9172936; exp_id[0] = 1'b0;
        exp_data[1] = 32'd82944;   exp_id[1] = 1'b1;
        exp_data[2] = 32'd9172936; exp_id[2] = 1'b0;
        exp_data[3] = 32'd82944;   exp_id[3] = 1'b1;
        apply_reset();
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 32'd783424; req0_b = 32'd8472456;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 32'd783424; req1_b = 32'd8472456;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (req0_ready !== !exp_id[i] || req1_ready !== exp_id[i]) begin
                tests_failed++;
                $display("FAIL contention_gnt[%0d]: r0=%0d r1=%0d, want grant to %0d",
                         i, req0_ready, req1_ready, exp_id[i]);
            end
            step();
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== exp_data[i] || resp_id !== exp_id[i]
                || resp_op !== !exp_id[i]) begin
                tests_failed++;
                $display("FAIL contention_resp[%0d]: valid=%0d data=%0d id=%0d op=%0d, want 1 %0d %0d %0d",
                         i, resp_valid, resp_data, resp_id, resp_op, exp_data[i], exp_id[i], !exp_id[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_backpressure();
        // A lone req0 transfer leaves last_grant at 0 so req1 wins the next contention.
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd267482; req0_b = 32'd817648;
        step();
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'd267482; req1_b = 32'd817648;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_first_gnt: r0=%0d r1=%0d, want 0 1", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (req0_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stall_ready[%0d]: r0=%0d, want 0", i, req0_ready);
            end
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== 32'd818682 || resp_id !== 1'b1 || resp_op !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%0d data=%0d id=%0d op=%0d, want 1 818682 1 1",
                         i, resp_valid, resp_data, resp_id, resp_op);
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release_gnt: r0=%0d, want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd266448 || resp_id !== 1'b0 || resp_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release_resp: valid=%0d data=%0d id=%0d op=%0d, want 1 266448 0 0",
                     resp_valid, resp_data, resp_id, resp_op);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_v [4];
        logic [W-1:0] b_v [4];
        logic [W-1:0] exp  [4];
        a_v[0] = 32'hFFFF0000; b_v[0] = 32'h12345678; exp[0] = 32'h12340000;
        a_v[1] = 32'hF0F0F0F0; b_v[1] = 32'hFFFFFFFF; exp[1] = 32'hF0F0F0F0;
        a_v[2] = 32'hAAAAAAAA; b_v[2] = 32'h55555555; exp[2] = 32'h00000000;
        a_v[3] = 32'hFFFFFFFF; b_v[3] = 32'hFFFFFFFF; exp[3] = 32'hFFFFFFFF;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_op = 1'b0; req0_a = a_v[i]; req0_b = b_v[i];
            #1;
            tests_run++;
            if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_gnt[%0d]: r0=%0d r1=%0d, want 1 0", i, req0_ready, req1_ready);
            end
            step();
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== exp[i] || resp_id !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_resp[%0d]: valid=%0d data=%h id=%0d, want 1 %h 0",
                         i, resp_valid, resp_data, resp_id, exp[i]);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_op();
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'd5742; req0_b = 32'd5742;
        step();
        req0_valid = 1'b0;
        resp_ready = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd5742) begin
            tests_failed++;
            $display("FAIL mid_reset_pre: valid=%0d data=%0d, want 1 5742", resp_valid, resp_data);
        end
        #1;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (resp_valid !== 1'b0 || resp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_async: valid=%0d data=%0d, want 0 0", resp_valid, resp_data);
        end
        step();
        reset_n = 1'b1;
        resp_ready = 1'b1;
        step();
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_gnt: r0=%0d r1=%0d, want 1 0", req0_ready, req1_ready);
        end
        step();
        tests_run++;
        if (resp_data !== 32'h0000_00FF || resp_id !== 1'b0 || resp_op !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_resp: data=%h id=%0d op=%0d, want 000000ff 0 1",
                     resp_data, resp_id, resp_op);
        end
    endtask

    task automatic test_lone_requester();
        // Both still valid: req1 wins now, leaving last_grant at 1.
        #1;
        tests_run++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL lone_setup_gnt: r0=%0d r1=%0d, want 0 1", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        req1_op = 1'b1; req1_a = 32'h0000_1200; req1_b = 32'h0000_0034;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests_run++;
            if (req1_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL lone_gnt[%0d]: r1=%0d, want 1", i, req1_ready);
            end
            step();
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== 32'h0000_1234 || resp_id !== 1'b1) begin
                tests_failed++;
                $display("FAIL lone_resp[%0d]: valid=%0d data=%h id=%0d, want 1 00001234 1",
                         i, resp_valid, resp_data, resp_id);
            end
        end
        // last_grant stayed 1, so req0 wins the next contention.
        req0_valid = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL lone_after_gnt: r0=%0d r1=%0d, want 1 0", req0_ready, req1_ready);
        end
        step();
        idle_inputs();
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        resp_ready = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_lone_requester();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
